// File: rtl/fsm_rd_pkg.sv
// -----------------------------------------------------------------------------
// fsm_rd_pkg
// Shared definitions for the table-programmable primary/twin Moore FSM.
//   - cfg_sel_e : selects the table a config write targets
//   - clog2/max2: constant helpers for deriving parameter widths
//   - st_base / st_shadow / st_make : pack and unpack a state index
//     laid out as {base, shadow}; shadow=0 is the primary, 1 is the twin
// -----------------------------------------------------------------------------
package fsm_rd_pkg;

   typedef enum logic {
      CFG_SEL_TRANS = 1'b0,
      CFG_SEL_OUT   = 1'b1
   } cfg_sel_e;

   function automatic int clog2(input int value);
      int res;
      int rem;
      res = 0;
      rem = value - 1;
      while (rem > 0) begin
         res = res + 1;
         rem = rem >> 1;
      end
      return res;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int st_base(input int st);
      return st >> 1;
   endfunction

   function automatic logic st_shadow(input int st);
      return st[0];
   endfunction

   function automatic int st_make(input int base, input logic shadow);
      return (base << 1) | int'(shadow);
   endfunction

endpackage

// File: rtl/fsm_rd_cfg_regs.sv
// -----------------------------------------------------------------------------
// fsm_rd_cfg_regs
// Configuration storage for fsm_rd_table: the transition table, the output
// table, the sticky lock flag, and decoding of config writes.
//
// Ports:
//   CLK, RST    clock (rising edge), asynchronous active-high reset
//   cfg_we      write strobe
//   cfg_sel     0 = transition table, 1 = output table
//   cfg_addr    sel0: {base, ptext}; sel1: state index
//   cfg_wdata   sel0: next base in low BIDX_W bits; sel1: code in low OUT_W
//   cfg_lock    sets locked at the next edge (sticky until RST)
//   locked      lock status
//   wr_fault    combinational: this cycle's write attempt is rejected
//   trans_addr  read address {base, ptext} for the next-state lookup
//   trans_data  next base index stored at trans_addr
//   out_addr    read address (state index) for the Moore output
//   out_data    output code stored at out_addr
// -----------------------------------------------------------------------------
module fsm_rd_cfg_regs
   import fsm_rd_pkg::*;
#(
   parameter int IN_W    = 2,
   parameter int OUT_W   = 8,
   parameter int N_BASE  = 4,
   parameter int BIDX_W  = clog2(N_BASE),
   parameter int STATE_W = BIDX_W + 1,
   parameter int CFG_AW  = max2(BIDX_W + IN_W, STATE_W),
   parameter int CFG_DW  = max2(OUT_W, BIDX_W)
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      cfg_we,
   input  logic                      cfg_sel,
   input  logic [CFG_AW-1:0]         cfg_addr,
   input  logic [CFG_DW-1:0]         cfg_wdata,
   input  logic                      cfg_lock,
   output logic                      locked,
   output logic                      wr_fault,
   input  logic [BIDX_W+IN_W-1:0]    trans_addr,
   output logic [BIDX_W-1:0]         trans_data,
   input  logic [STATE_W-1:0]        out_addr,
   output logic [OUT_W-1:0]          out_data
);

   localparam int TA_W    = BIDX_W + IN_W;
   localparam int N_TRANS = 1 << TA_W;
   localparam int N_STATE = 2 * N_BASE;

   logic [BIDX_W-1:0] tab     [N_TRANS];
   logic [OUT_W-1:0]  out_tab [N_STATE];

   logic [BIDX_W-1:0] addr_base;
   logic              addr_hi_clear;
   logic              trans_ok;
   logic              out_ok;
   logic              addr_ok;
   logic              wr_apply;

   // A transition address is only valid when every bit above {base, ptext}
   // is zero and the base field names an existing base state.
   assign addr_base     = cfg_addr[TA_W-1:IN_W];
   assign addr_hi_clear = ((cfg_addr >> TA_W) == '0);
   assign trans_ok      = addr_hi_clear && (int'(addr_base) < N_BASE);
   assign out_ok        = (int'(cfg_addr) < N_STATE);
   assign addr_ok       = (cfg_sel == CFG_SEL_OUT) ? out_ok : trans_ok;

   // Lock is checked against the current flag, so a write issued together
   // with cfg_lock still lands.
   assign wr_apply = cfg_we && !locked && addr_ok;
   assign wr_fault = cfg_we && (locked || !addr_ok);

   assign trans_data = tab[trans_addr];
   assign out_data   = out_tab[out_addr];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < N_TRANS; i++) begin
            tab[i] <= '0;
         end
         for (int i = 0; i < N_STATE; i++) begin
            out_tab[i] <= '0;
         end
         locked <= 1'b0;
      end else begin
         if (wr_apply) begin
            if (cfg_sel == CFG_SEL_OUT) begin
               out_tab[cfg_addr[STATE_W-1:0]] <= cfg_wdata[OUT_W-1:0];
            end else begin
               tab[cfg_addr[TA_W-1:0]] <= cfg_wdata[BIDX_W-1:0];
            end
         end
         if (cfg_lock) begin
            locked <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/fsm_rd_table.sv
// -----------------------------------------------------------------------------
// fsm_rd_table
// Table-programmable Moore FSM. Each base state has a primary and a twin;
// a self-transition on a base alternates between them so they can carry
// different output codes. Tables are written through the config port and
// can be locked until reset.
//
// Ports:
//   CLK, RST    clock (rising edge), asynchronous active-high reset
//   en          advance the state this cycle
//   ptext       input symbol
//   rtext       Moore output, out_tab[state]
//   state_o     current state index {base, shadow}
//   cfg_we      config write strobe
//   cfg_sel     0 = transition table, 1 = output table
//   cfg_addr    sel0: {base, ptext}; sel1: state index
//   cfg_wdata   sel0: next base (low BIDX_W bits); sel1: code (low OUT_W)
//   cfg_lock    set the sticky lock
//   locked      lock status
//   err         one-cycle pulse after any faulting edge
// -----------------------------------------------------------------------------
module fsm_rd_table
   import fsm_rd_pkg::*;
#(
   parameter int IN_W    = 2,
   parameter int OUT_W   = 8,
   parameter int N_BASE  = 4,
   parameter int BIDX_W  = clog2(N_BASE),
   parameter int STATE_W = BIDX_W + 1,
   parameter int CFG_AW  = max2(BIDX_W + IN_W, STATE_W),
   parameter int CFG_DW  = max2(OUT_W, BIDX_W)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                en,
   input  logic [IN_W-1:0]     ptext,
   output logic [OUT_W-1:0]    rtext,
   output logic [STATE_W-1:0]  state_o,
   input  logic                cfg_we,
   input  logic                cfg_sel,
   input  logic [CFG_AW-1:0]   cfg_addr,
   input  logic [CFG_DW-1:0]   cfg_wdata,
   input  logic                cfg_lock,
   output logic                locked,
   output logic                err
);

   logic [STATE_W-1:0]      state;
   logic [STATE_W-1:0]      state_next;
   logic [BIDX_W-1:0]       cur_base;
   logic                    cur_shadow;
   logic [BIDX_W-1:0]       nxt_base;
   logic [BIDX_W+IN_W-1:0]  trans_addr;
   logic [OUT_W-1:0]        out_data;
   logic                    wr_fault;
   logic                    trans_fault;
   logic                    err_q;

   assign cur_base   = BIDX_W'(st_base(int'(state)));
   assign cur_shadow = st_shadow(int'(state));
   assign trans_addr = {cur_base, ptext};

   fsm_rd_cfg_regs #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .N_BASE  (N_BASE),
      .BIDX_W  (BIDX_W),
      .STATE_W (STATE_W),
      .CFG_AW  (CFG_AW),
      .CFG_DW  (CFG_DW)
   ) u_cfg (
      .CLK        (CLK),
      .RST        (RST),
      .cfg_we     (cfg_we),
      .cfg_sel    (cfg_sel),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cfg_lock   (cfg_lock),
      .locked     (locked),
      .wr_fault   (wr_fault),
      .trans_addr (trans_addr),
      .trans_data (nxt_base),
      .out_addr   (state),
      .out_data   (out_data)
   );

   // Next-state rule. The lookup reads the table as it stands before this
   // edge, so a concurrent config write only affects later transitions.
   // An out-of-range next base can only exist when N_BASE is not a power
   // of two; it sends the machine home and raises err.
   always_comb begin
      state_next  = state;
      trans_fault = 1'b0;
      if (en) begin
         if (int'(nxt_base) >= N_BASE) begin
            state_next  = '0;
            trans_fault = 1'b1;
         end else if (nxt_base == cur_base) begin
            state_next = STATE_W'(st_make(int'(cur_base), ~cur_shadow));
         end else begin
            state_next = STATE_W'(st_make(int'(nxt_base), 1'b0));
         end
      end
   end

   // Faults from the config port and from the transition collapse into a
   // single registered pulse.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_next;
         err_q <= wr_fault | trans_fault;
      end
   end

   assign state_o = state;
   assign rtext   = out_data;
   assign err     = err_q;

endmodule

// File: tb/tb_fsm_rd_table.sv
module tb_fsm_rd_table;

   logic       CLK;
   logic       RST;

   // N_BASE=4 instance
   logic       en4, we4, sel4, lock4;
   logic [1:0] p4;
   logic [3:0] addr4;
   logic [7:0] wd4;
   logic [7:0] rtext4;
   logic [2:0] state4;
   logic       locked4, err4;

   // N_BASE=3 instance
   logic       en3, we3, sel3, lock3;
   logic [1:0] p3;
   logic [3:0] addr3;
   logic [7:0] wd3;
   logic [7:0] rtext3;
   logic [2:0] state3;
   logic       locked3, err3;

   int checks;
   int failures;

   fsm_rd_table #(.IN_W(2), .OUT_W(8), .N_BASE(4)) u_dut4 (
      .CLK(CLK), .RST(RST), .en(en4), .ptext(p4), .rtext(rtext4), .state_o(state4),
      .cfg_we(we4), .cfg_sel(sel4), .cfg_addr(addr4), .cfg_wdata(wd4),
      .cfg_lock(lock4), .locked(locked4), .err(err4)
   );

   fsm_rd_table #(.IN_W(2), .OUT_W(8), .N_BASE(3)) u_dut3 (
      .CLK(CLK), .RST(RST), .en(en3), .ptext(p3), .rtext(rtext3), .state_o(state3),
      .cfg_we(we3), .cfg_sel(sel3), .cfg_addr(addr3), .cfg_wdata(wd3),
      .cfg_lock(lock3), .locked(locked3), .err(err3)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- reference model of the N_BASE=4 instance ----------------
   int m_tab [16];   // next base for (base*4 + ptext)
   int m_out [8];    // output code per state
   int m_state;      // 2*base + shadow
   bit m_locked;
   bit m_err;

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) m_tab[i] = 0;
      for (int i = 0; i < 8; i++) m_out[i] = 0;
      m_state  = 0;
      m_locked = 0;
      m_err    = 0;
   endfunction

   function automatic void model_step();
      int b, s, nb, ns, a;
      bit fault;
      fault = 0;
      ns    = m_state;
      a     = int'(addr4);
      if (en4) begin
         b  = m_state / 2;
         s  = m_state % 2;
         nb = m_tab[b * 4 + int'(p4)];
         if (nb >= 4) begin
            ns = 0;
            fault = 1;
         end else if (nb == b) begin
            ns = 2 * b + (1 - s);
         end else begin
            ns = 2 * nb;
         end
      end
      if (we4) begin
         if (m_locked) fault = 1;
         else if (!sel4) begin
            if (a / 4 >= 4) fault = 1;
            else m_tab[a] = int'(wd4) % 4;
         end else begin
            if (a >= 8) fault = 1;
            else m_out[a] = int'(wd4);
         end
      end
      if (lock4) m_locked = 1;
      m_state = ns;
      m_err   = fault;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, " state"},  32'(state4),  32'(m_state));
      chk({tag, " rtext"},  32'(rtext4),  32'(m_out[m_state]));
      chk({tag, " err"},    32'(err4),    32'(m_err));
      chk({tag, " locked"}, 32'(locked4), 32'(m_locked));
   endtask

   task automatic idle4();
      en4 = 0; we4 = 0; sel4 = 0; lock4 = 0; p4 = 0; addr4 = 0; wd4 = 0;
   endtask

   task automatic idle3();
      en3 = 0; we3 = 0; sel3 = 0; lock3 = 0; p3 = 0; addr3 = 0; wd3 = 0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       en;
      logic [1:0] p;
      logic       we;
      logic       sel;
      logic [3:0] addr;
      logic [7:0] wd;
      logic       lock;
      logic [2:0] es;
      logic [7:0] er;
      logic       ee;
      logic       el;
   } vec_t;

   vec_t vt[$];

   function automatic void add(input logic en, input logic [1:0] p, input logic we,
                               input logic sel, input logic [3:0] addr, input logic [7:0] wd,
                               input logic lock, input logic [2:0] es, input logic [7:0] er,
                               input logic ee, input logic el);
      vec_t v;
      v.en = en; v.p = p; v.we = we; v.sel = sel; v.addr = addr; v.wd = wd;
      v.lock = lock; v.es = es; v.er = er; v.ee = ee; v.el = el;
      vt.push_back(v);
   endfunction

   logic [7:0] otab_init [8];

   initial begin
      checks = 0;
      failures = 0;
      otab_init = '{8'hC4, 8'h38, 8'h38, 8'h64, 8'h64, 8'hE4, 8'h98, 8'h98};

      // output table load
      for (int i = 0; i < 8; i++) add(0, 0, 1, 1, 4'(i), otab_init[i], 0, 0, 8'hC4, 0, 0);
      // transitions from base 0: 11->1, 00->0, 01->1, 10->2
      add(0, 0, 1, 0, 4'b0011, 8'd1, 0, 0, 8'hC4, 0, 0);
      add(0, 0, 1, 0, 4'b0000, 8'd0, 0, 0, 8'hC4, 0, 0);
      add(0, 0, 1, 0, 4'b0001, 8'd1, 0, 0, 8'hC4, 0, 0);
      add(0, 0, 1, 0, 4'b0010, 8'd2, 0, 0, 8'hC4, 0, 0);
      // run 00,00,11
      add(1, 0, 0, 0, 0, 0, 0, 1, 8'h38, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 8'hC4, 0, 0);
      add(1, 3, 0, 0, 0, 0, 0, 2, 8'h38, 0, 0);
      // twin toggle on base 1
      add(0, 0, 1, 0, 4'b0101, 8'd1, 0, 2, 8'h38, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0, 3, 8'h64, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0, 2, 8'h38, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0, 3, 8'h64, 0, 0);
      // en=0 hold with changing ptext
      add(0, 0, 0, 0, 0, 0, 0, 3, 8'h64, 0, 0);
      add(0, 3, 0, 0, 0, 0, 0, 3, 8'h64, 0, 0);
      add(0, 2, 0, 0, 0, 0, 0, 3, 8'h64, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 3, 8'h64, 0, 0);
      // bad output address, then single-cycle err
      add(0, 0, 1, 1, 4'd8, 8'hFF, 0, 3, 8'h64, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 3, 8'h64, 0, 0);
      // back to 0: out_tab[0] must be untouched
      add(1, 0, 0, 0, 0, 0, 0, 0, 8'hC4, 0, 0);
      // write + en same cycle: old table used, new value next time
      add(1, 2, 1, 0, 4'b0010, 8'd3, 0, 4, 8'h64, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 8'hC4, 0, 0);
      add(1, 2, 0, 0, 0, 0, 0, 6, 8'h98, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 8'hC4, 0, 0);
      // lock together with a write, then rejected writes
      add(0, 0, 1, 1, 4'd0, 8'hAA, 1, 0, 8'hAA, 0, 1);
      add(0, 0, 1, 1, 4'd0, 8'h55, 0, 0, 8'hAA, 1, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 8'hAA, 0, 1);
      add(0, 0, 1, 0, 4'd0, 8'd1, 0, 0, 8'hAA, 1, 1);
      add(1, 0, 0, 0, 0, 0, 0, 1, 8'h38, 0, 1);

      // reset state
      RST = 1'b1;
      idle4();
      idle3();
      model_reset();
      #3;
      chk("reset state4",  32'(state4),  0);
      chk("reset rtext4",  32'(rtext4),  0);
      chk("reset locked4", 32'(locked4), 0);
      chk("reset err4",    32'(err4),    0);
      chk("reset state3",  32'(state3),  0);
      #9;
      RST = 1'b0;

      // directed table
      for (int i = 0; i < vt.size(); i++) begin
         en4 = vt[i].en; p4 = vt[i].p; we4 = vt[i].we; sel4 = vt[i].sel;
         addr4 = vt[i].addr; wd4 = vt[i].wd; lock4 = vt[i].lock;
         tick();
         chk($sformatf("vec%0d state", i),  32'(state4),  32'(vt[i].es));
         chk($sformatf("vec%0d rtext", i),  32'(rtext4),  32'(vt[i].er));
         chk($sformatf("vec%0d err", i),    32'(err4),    32'(vt[i].ee));
         chk($sformatf("vec%0d locked", i), 32'(locked4), 32'(vt[i].el));
      end

      // mid-run reset clears tables and lock
      idle4();
      #2;
      RST = 1'b1;
      model_reset();
      #1;
      chk("midreset state", 32'(state4), 0);
      chk("midreset rtext", 32'(rtext4), 0);
      chk("midreset locked", 32'(locked4), 0);
      #2;
      RST = 1'b0;
      // after reset the tables are empty: base 0 toggles with rtext 0
      en4 = 1; p4 = 2;
      tick();
      chk("cleared tab state", 32'(state4), 1);
      chk("cleared tab rtext", 32'(rtext4), 0);
      en4 = 1; p4 = 2;
      tick();
      chk("cleared tab back", 32'(state4), 0);

      // reach state 5, lock, then reset asynchronously
      idle4(); we4 = 1; sel4 = 0; addr4 = 4'b0010; wd4 = 8'd2; tick(); check_model("prog a");
      idle4(); we4 = 1; sel4 = 0; addr4 = 4'b1001; wd4 = 8'd2; tick(); check_model("prog b");
      idle4(); we4 = 1; sel4 = 1; addr4 = 4'd5;    wd4 = 8'hE4; lock4 = 1; tick(); check_model("prog c");
      idle4(); en4 = 1; p4 = 2; tick();
      chk("to4 state", 32'(state4), 4);
      idle4(); en4 = 1; p4 = 1; tick();
      chk("to5 state", 32'(state4), 5);
      chk("to5 rtext", 32'(rtext4), 32'hE4);
      chk("to5 locked", 32'(locked4), 1);
      idle4();
      #2;
      RST = 1'b1;
      model_reset();
      #1;
      chk("async rst state", 32'(state4), 0);
      chk("async rst rtext", 32'(rtext4), 0);
      chk("async rst locked", 32'(locked4), 0);
      chk("async rst err", 32'(err4), 0);
      #2;
      RST = 1'b0;

      // N_BASE=3: invalid next base and bad addresses
      idle3(); en3 = 1; p3 = 1; tick();
      chk("n3 toggle state", 32'(state3), 1);
      chk("n3 toggle err", 32'(err3), 0);
      idle3(); we3 = 1; sel3 = 0; addr3 = 4'd0; wd3 = 8'd3; tick();
      chk("n3 prog err", 32'(err3), 0);
      chk("n3 prog state", 32'(state3), 1);
      idle3(); en3 = 1; p3 = 0; tick();
      chk("n3 bad nb state", 32'(state3), 0);
      chk("n3 bad nb err", 32'(err3), 1);
      idle3(); tick();
      chk("n3 err clears", 32'(err3), 0);
      idle3(); we3 = 1; sel3 = 0; addr3 = 4'd12; wd3 = 8'd1; tick();
      chk("n3 bad base err", 32'(err3), 1);
      idle3(); we3 = 1; sel3 = 1; addr3 = 4'd6; wd3 = 8'h77; tick();
      chk("n3 bad out err", 32'(err3), 1);
      chk("n3 bad out rtext", 32'(rtext3), 0);
      idle3(); we3 = 1; sel3 = 1; addr3 = 4'd6; wd3 = 8'h77; en3 = 1; p3 = 0; tick();
      chk("n3 double fault err", 32'(err3), 1);
      chk("n3 double fault state", 32'(state3), 0);
      idle3(); tick();
      chk("n3 single pulse", 32'(err3), 0);

      // randomized run against the model
      for (int i = 0; i < 400; i++) begin
         en4   = ($urandom_range(0, 9) < 7);
         p4    = 2'($urandom_range(0, 3));
         we4   = ($urandom_range(0, 9) < 4);
         sel4  = 1'($urandom_range(0, 1));
         addr4 = 4'($urandom_range(0, 15));
         wd4   = 8'($urandom_range(0, 255));
         lock4 = (i > 300) && ($urandom_range(0, 49) == 0);
         tick();
         check_model($sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
